pwm_generator: RTL and testbench

PWM_GENERATOR -- requirements
Module: pwm_generator

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_compare.sv | 42 ++++
 rtl/pwm_generator.sv | 103 ++++++++++
 tb/tb_pwm_generator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

    localparam int PERIOD     = 512;
    localparam int TIME_WIDTH = 9;

    typedef logic [TIME_WIDTH-1:0] time_t;

    localparam time_t TIME_MAX = time_t'(PERIOD - 1);

endpackage

// File: rtl/pwm_compare.sv
// One PWM channel: compares the period counter against an active
// rise/fall window and registers the result.
module pwm_compare
    import pwm_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [TIME_WIDTH-1:0] rise_i,
    input  logic [TIME_WIDTH-1:0] fall_i,
    input  logic [TIME_WIDTH-1:0] time_i,
    output logic                  pwm_o
);

    logic pwm_d;
    logic pwm_q;
    logic lt;
    logic gt;

    assign lt = rise_i < fall_i;
    assign gt = rise_i > fall_i;

    // rise > fall describes a pulse that wraps across the period end
    always_comb begin
        pwm_d = 1'b0;
        unique case (1'b1)
            lt:      pwm_d = (time_i >= rise_i) && (time_i < fall_i);
            gt:      pwm_d = (time_i >= rise_i) || (time_i < fall_i);
            default: pwm_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_generator.sv
// Multi-channel PWM generator: period counter, double-buffered
// rise/fall registers applied only at period boundaries.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int DEPTH = 249
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        SYNC,
    input  logic                        DIN_VALID,
    input  logic [TIME_WIDTH*DEPTH-1:0] RISE,
    input  logic [TIME_WIDTH*DEPTH-1:0] FALL,
    output logic [DEPTH-1:0]            PWM_OUT,
    output logic [TIME_WIDTH-1:0]       TIME_CNT,
    output logic                        UPDATE_PENDING
);

    time_t cnt_q;
    time_t cnt_d;
    logic  pend_q;
    logic  pend_d;
    logic  boundary;

    time_t sh_rise_q [DEPTH];
    time_t sh_fall_q [DEPTH];
    time_t ac_rise_q [DEPTH];
    time_t ac_fall_q [DEPTH];
    time_t sh_rise_d [DEPTH];
    time_t sh_fall_d [DEPTH];
    time_t ac_rise_d [DEPTH];
    time_t ac_fall_d [DEPTH];

    // a boundary is any cycle whose next edge loads 0 into the counter
    assign boundary = (cnt_q == TIME_MAX) || SYNC;

    always_comb begin
        cnt_d  = boundary ? '0 : cnt_q + 1'b1;
        pend_d = pend_q;
        if (boundary) begin
            pend_d = 1'b0;
        end else if (DIN_VALID) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sh_rise_d[i] = sh_rise_q[i];
            sh_fall_d[i] = sh_fall_q[i];
            ac_rise_d[i] = ac_rise_q[i];
            ac_fall_d[i] = ac_fall_q[i];
            if (DIN_VALID) begin
                sh_rise_d[i] = RISE[i*TIME_WIDTH +: TIME_WIDTH];
                sh_fall_d[i] = FALL[i*TIME_WIDTH +: TIME_WIDTH];
            end
            if (boundary && DIN_VALID) begin
                ac_rise_d[i] = RISE[i*TIME_WIDTH +: TIME_WIDTH];
                ac_fall_d[i] = FALL[i*TIME_WIDTH +: TIME_WIDTH];
            end else if (boundary && pend_q) begin
                ac_rise_d[i] = sh_rise_q[i];
                ac_fall_d[i] = sh_fall_q[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                sh_rise_q[i] <= '0;
                sh_fall_q[i] <= '0;
                ac_rise_q[i] <= '0;
                ac_fall_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            for (int i = 0; i < DEPTH; i++) begin
                sh_rise_q[i] <= sh_rise_d[i];
                sh_fall_q[i] <= sh_fall_d[i];
                ac_rise_q[i] <= ac_rise_d[i];
                ac_fall_q[i] <= ac_fall_d[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ch
        pwm_compare u_cmp (
            .clk_i  (CLK),
            .rst_ni (RST_N),
            .rise_i (ac_rise_q[g]),
            .fall_i (ac_fall_q[g]),
            .time_i (cnt_q),
            .pwm_o  (PWM_OUT[g])
        );
    end

    assign TIME_CNT       = cnt_q;
    assign UPDATE_PENDING = pend_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: a reference model predicts
// counter, pending flag and per-channel PWM each cycle.
module tb_pwm_generator;

    localparam int D = 4;
    localparam int W = 9;

    logic           clk;
    logic           rst_n;
    logic           sync;
    logic           din_valid;
    logic [W*D-1:0] rise;
    logic [W*D-1:0] fall;
    logic [D-1:0]   pwm_out;
    logic [W-1:0]   time_cnt;
    logic           upd_pend;

    int total = 0;
    int bad   = 0;

    int m_t;
    bit m_pend;
    int m_sr [D];
    int m_sf [D];
    int m_ar [D];
    int m_af [D];
    logic [D-1:0] exp_q [$];

    pwm_generator #(.DEPTH(D)) dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .SYNC           (sync),
        .DIN_VALID      (din_valid),
        .RISE           (rise),
        .FALL           (fall),
        .PWM_OUT        (pwm_out),
        .TIME_CNT       (time_cnt),
        .UPDATE_PENDING (upd_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // high iff t lies within [r, f) measured modulo the period
    function automatic bit ref_bit(input int t, input int r, input int f);
        return ((t - r + 512) % 512) < ((f - r + 512) % 512);
    endfunction

    task automatic model_reset();
        m_t    = 0;
        m_pend = 0;
        for (int i = 0; i < D; i++) begin
            m_sr[i] = 0;
            m_sf[i] = 0;
            m_ar[i] = 0;
            m_af[i] = 0;
        end
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            logic [D-1:0] e;
            logic [D-1:0] got;
            bit bnd;
            for (int i = 0; i < D; i++) e[i] = ref_bit(m_t, m_ar[i], m_af[i]);
            exp_q.push_back(e);
            bnd = (m_t == 511) || sync;
            for (int i = 0; i < D; i++) begin
                if (din_valid) begin
                    m_sr[i] = int'(rise[i*W +: W]);
                    m_sf[i] = int'(fall[i*W +: W]);
                end
                if (bnd && din_valid) begin
                    m_ar[i] = m_sr[i];
                    m_af[i] = m_sf[i];
                end else if (bnd && m_pend) begin
                    m_ar[i] = m_sr[i];
                    m_af[i] = m_sf[i];
                end
            end
            if (bnd) m_pend = 0;
            else if (din_valid) m_pend = 1;
            m_t = bnd ? 0 : m_t + 1;
            #1;
            if (rst_n) begin
                got = exp_q.pop_front();
                chk("pwm", pwm_out, got);
                chk("tcnt", time_cnt, m_t);
                chk("pend", upd_pend, m_pend);
            end
        end
    end

    task automatic set_ch(input int ch, input int r, input int f);
        rise[ch*W +: W] = r[W-1:0];
        fall[ch*W +: W] = f[W-1:0];
    endtask

    task automatic wait_t(input int target);
        int n;
        n = 0;
        while (m_t != target && n < 1100) begin
            @(negedge clk);
            n++;
        end
        if (m_t != target) chk("timeout", 1, 0);
    endtask

    task automatic pulse(input bit dv, input bit sy);
        din_valid = dv;
        sync      = sy;
        @(negedge clk);
        din_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic count_hi(input int n, input int ch, output int c);
        c = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (ch < 0) begin
                if (|pwm_out) c++;
            end else if (pwm_out[ch]) begin
                c++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int c;
        rst_n     = 1'b0;
        sync      = 1'b0;
        din_valid = 1'b0;
        rise      = '0;
        fall      = '0;
        model_reset();
        #12;
        chk("rst_t", time_cnt, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_pend", upd_pend, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_inc", time_cnt, 1);

        set_ch(0, 100, 200);
        set_ch(1, 450, 50);
        set_ch(2, 300, 300);
        set_ch(3, 0, 511);
        wait_t(250);
        pulse(1'b1, 1'b0);
        chk("pend_251", upd_pend, 1);
        wait_t(5);
        count_hi(512, 0, c);
        chk("w100", c, 100);
        count_hi(512, 1, c);
        chk("w112", c, 112);
        count_hi(1024, 2, c);
        chk("w0", c, 0);
        count_hi(512, 3, c);
        chk("w511", c, 511);

        set_ch(0, 10, 20);
        set_ch(3, 511, 0);
        wait_t(511);
        pulse(1'b1, 1'b0);
        chk("pend_wrap", upd_pend, 0);
        count_hi(512, 0, c);
        chk("w10", c, 10);

        set_ch(0, 400, 100);
        wait_t(100);
        pulse(1'b1, 1'b0);
        chk("pend_sy", upd_pend, 1);
        wait_t(300);
        pulse(1'b0, 1'b1);
        chk("sync_t0", time_cnt, 0);
        chk("sync_pend", upd_pend, 0);
        count_hi(512, 0, c);
        chk("w212", c, 212);

        set_ch(0, 0, 300);
        set_ch(1, 150, 250);
        wait_t(150);
        pulse(1'b1, 1'b0);
        wait_t(200);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_pwm", pwm_out, 0);
        chk("arst_t", time_cnt, 0);
        chk("arst_pend", upd_pend, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_hi(600, -1, c);
        chk("post_rst", c, 0);

        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(1, 700)) @(negedge clk);
            for (int i = 0; i < D; i++) begin
                set_ch(i, int'($urandom_range(0, 511)),
                       int'($urandom_range(0, 511)));
            end
            pulse(1'b1, k[0] && k[1]);
            if (k == 5) begin
                repeat (3) @(negedge clk);
                pulse(1'b0, 1'b1);
            end
        end
        repeat (600) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
